// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   SIZE_BYTE / SIZE_HALF / SIZE_WORD : access size codes carried on ls_size / mem_size
//   state_t                           : arbiter FSM states (IDLE, BUSY)
//   owner_t                           : which requester owns the in-flight transaction
package mem_arb_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_perf_counters.sv
// Wrapping performance counters for the memory port arbiter.
// Only instantiated when ARB_PERF_CNT_EN is defined.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   if_wait           : fetch is requesting but was not granted this cycle
//   ls_grant          : load/store grant this cycle
//   force_grant       : starvation-forced fetch grant this cycle
//   perf_if_wait_cnt  : count of if_wait cycles
//   perf_ls_cnt       : count of LS grants
//   perf_force_cnt    : count of forced fetch grants
module arb_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_wait,
    input  logic             ls_grant,
    input  logic             force_grant,
    output logic [CNT_W-1:0] perf_if_wait_cnt,
    output logic [CNT_W-1:0] perf_ls_cnt,
    output logic [CNT_W-1:0] perf_force_cnt
);

    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    // Event counters; they wrap naturally on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_wait_cnt <= '0;
            perf_ls_cnt      <= '0;
            perf_force_cnt   <= '0;
        end else begin
            if (if_wait)     perf_if_wait_cnt <= perf_if_wait_cnt + ONE_C;
            if (ls_grant)    perf_ls_cnt      <= perf_ls_cnt + ONE_C;
            if (force_grant) perf_force_cnt   <= perf_force_cnt + ONE_C;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and the
// load/store unit. Load/store has default priority; a starvation counter forces a
// fetch through after STARVE_LIMIT consecutive LS grants. Fetch responses that see
// a flush between grant and completion are discarded. One transaction in flight.
// Optional feature macro: ARB_PERF_CNT_EN adds perf_if_wait_cnt, perf_ls_cnt and
// perf_force_cnt outputs (CNT_W bits each).
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   if_req/if_addr -> if_gnt         : fetch request / accept pulse (combinational)
//   if_rvalid/if_rdata               : fetch response (registered)
//   ls_req/ls_we/ls_size/ls_addr/ls_wdata -> ls_gnt : load/store request / accept
//   ls_rvalid/ls_rdata               : load data or store completion (rdata 0 for stores)
//   flush                            : PC redirect, kills pending and in-flight fetch results
//   mem_valid/we/size/addr/wdata     : registered memory request
//   mem_ready/mem_rdata              : memory handshake and read data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [31:0]      if_rdata,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [1:0]       ls_size,
    input  logic [31:0]      ls_addr,
    input  logic [31:0]      ls_wdata,
    output logic             ls_gnt,
    output logic             ls_rvalid,
    output logic [31:0]      ls_rdata,
    input  logic             flush,
    output logic             mem_valid,
    output logic             mem_we,
    output logic [1:0]       mem_size,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
`ifdef ARB_PERF_CNT_EN
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] perf_if_wait_cnt,
    output logic [CNT_W-1:0] perf_ls_cnt,
    output logic [CNT_W-1:0] perf_force_cnt
`else
    input  logic [31:0]      mem_rdata
`endif
);

    localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] LIMIT_C = SC_W'(STARVE_LIMIT);

    state_t          state_r;
    state_t          state_next_s;
    owner_t          owner_r;
    logic            drop_r;
    logic [SC_W-1:0] starve_cnt_r;
    logic            free_s;
    logic            force_s;
    logic            if_win_s;
    logic            ls_win_s;
    logic            complete_s;
    logic            if_rvalid_r;
    logic            ls_rvalid_r;
    logic [31:0]     if_rdata_r;
    logic [31:0]     ls_rdata_r;

    // Arbitration, grant pulses and next-state decode.
    always_comb begin
        free_s       = 1'b0;
        force_s      = 1'b0;
        if_win_s     = 1'b0;
        ls_win_s     = 1'b0;
        state_next_s = state_r;
        complete_s   = 1'b0;

        case (state_r)
            IDLE:    free_s = 1'b1;
            BUSY:    free_s = mem_ready;
            default: free_s = 1'b0;
        endcase
        complete_s = (state_r == BUSY) && mem_ready;

        // A zero limit disables forcing entirely.
        force_s = (STARVE_LIMIT != 0) && if_req && (starve_cnt_r == LIMIT_C);

        // Fetch is never granted while a redirect is being signalled.
        if (force_s && !flush) begin
            if_win_s = 1'b1;
        end else if (ls_req) begin
            ls_win_s = 1'b1;
        end else if (if_req && !flush) begin
            if_win_s = 1'b1;
        end else begin
            if_win_s = 1'b0;
            ls_win_s = 1'b0;
        end

        if (free_s) begin
            state_next_s = (if_win_s || ls_win_s) ? BUSY : IDLE;
        end else begin
            state_next_s = state_r;
        end
    end

    // Grants are held low while reset is asserted so every output reads zero.
    assign if_gnt    = free_s && if_win_s && !rst;
    assign ls_gnt    = free_s && ls_win_s && !rst;
    assign if_rvalid = if_rvalid_r;
    assign if_rdata  = if_rdata_r;
    assign ls_rvalid = ls_rvalid_r;
    assign ls_rdata  = ls_rdata_r;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // Starvation counter: counts LS grants that bypass a waiting fetch, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt_r <= '0;
        end else if (ls_gnt && (starve_cnt_r != LIMIT_C)) begin
            starve_cnt_r <= starve_cnt_r + SC_W'(1);
        end
    end

    // Memory request register: loaded from the winner in each free cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= 2'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            owner_r   <= OWNER_IF;
        end else if (free_s) begin
            if (if_win_s) begin
                mem_valid <= 1'b1;
                mem_we    <= 1'b0;
                mem_size  <= SIZE_WORD;
                mem_addr  <= if_addr;
                mem_wdata <= 32'd0;
                owner_r   <= OWNER_IF;
            end else if (ls_win_s) begin
                mem_valid <= 1'b1;
                mem_we    <= ls_we;
                mem_size  <= ls_size;
                mem_addr  <= ls_addr;
                mem_wdata <= ls_wdata;
                owner_r   <= OWNER_LS;
            end else begin
                mem_valid <= 1'b0;
            end
        end
    end

    // Sticky drop flag: remembers a flush seen while a fetch is waiting on memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_r <= 1'b0;
        end else if (free_s) begin
            drop_r <= 1'b0;
        end else if ((state_r == BUSY) && (owner_r == OWNER_IF)) begin
            drop_r <= drop_r | flush;
        end
    end

    // Response registers, routed by the owner tag of the completing transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rvalid_r <= 1'b0;
            ls_rvalid_r <= 1'b0;
            if_rdata_r  <= 32'd0;
            ls_rdata_r  <= 32'd0;
        end else begin
            if_rvalid_r <= complete_s && (owner_r == OWNER_IF) && !(drop_r || flush);
            ls_rvalid_r <= complete_s && (owner_r == OWNER_LS);
            if (complete_s && (owner_r == OWNER_IF)) begin
                if_rdata_r <= mem_rdata;
            end
            if (complete_s && (owner_r == OWNER_LS)) begin
                ls_rdata_r <= mem_we ? 32'd0 : mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    arb_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk              (clk),
        .rst              (rst),
        .if_wait          (if_req && !if_gnt),
        .ls_grant         (ls_gnt),
        .force_grant      (if_gnt && force_s),
        .perf_if_wait_cnt (perf_if_wait_cnt),
        .perf_ls_cnt      (perf_ls_cnt),
        .perf_force_cnt   (perf_force_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_LIMIT = 4).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        flush;
    logic        mem_valid;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_wait_cnt;
    logic [31:0] perf_ls_cnt;
    logic [31:0] perf_force_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_size   (ls_size),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .flush     (flush),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
`ifdef ARB_PERF_CNT_EN
        .mem_rdata        (mem_rdata),
        .perf_if_wait_cnt (perf_if_wait_cnt),
        .perf_ls_cnt      (perf_ls_cnt),
        .perf_force_cnt   (perf_force_cnt)
`else
        .mem_rdata (mem_rdata)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Registered outputs are observed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_gnt"},    {31'd0, if_gnt},    32'd0);
        chk({tag, "_ls_gnt"},    {31'd0, ls_gnt},    32'd0);
        chk({tag, "_if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
        chk({tag, "_ls_rvalid"}, {31'd0, ls_rvalid}, 32'd0);
        chk({tag, "_if_rdata"},  if_rdata,           32'd0);
        chk({tag, "_ls_rdata"},  ls_rdata,           32'd0);
        chk({tag, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
        chk({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
        chk({tag, "_mem_size"},  {30'd0, mem_size},  32'd0);
        chk({tag, "_mem_addr"},  mem_addr,           32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,          32'd0);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; ls_req = 1'b0; ls_we = 1'b0;
        ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0; flush = 1'b0;
        mem_ready = 1'b0; mem_rdata = 32'd0;

        // Reset state
        #2;
        chk_all_zero("reset");
        tick(); tick();
        rst = 1'b0;

        // 1: single fetch
        tick();
        if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b1; mem_rdata = 32'h13;
        #1 chk("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("t1_ls_gnt", {31'd0, ls_gnt}, 32'd0);
        tick();
        if_req = 1'b0;
        chk("t1_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h40);
        chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
        chk("t1_mem_size", {30'd0, mem_size}, 32'd2);
        chk("t1_if_rvalid_early", {31'd0, if_rvalid}, 32'd0);
        tick();
        chk("t1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("t1_if_rdata", if_rdata, 32'h13);
        chk("t1_mem_idle", {31'd0, mem_valid}, 32'd0);
        tick();
        chk("t1_if_rvalid_pulse", {31'd0, if_rvalid}, 32'd0);

        // 2: simultaneous fetch and load, LS first
        if_req = 1'b1; if_addr = 32'h44;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h100;
        #1 chk("t2_ls_gnt", {31'd0, ls_gnt}, 32'd1);
        chk("t2_if_gnt_blocked", {31'd0, if_gnt}, 32'd0);
        tick();
        ls_req = 1'b0; mem_rdata = 32'hDEADBEEF;
        chk("t2_mem_addr_ls", mem_addr, 32'h100);
        #1 chk("t2_if_gnt", {31'd0, if_gnt}, 32'd1);
        tick();
        if_req = 1'b0; mem_rdata = 32'h11112222;
        chk("t2_ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
        chk("t2_ls_rdata", ls_rdata, 32'hDEADBEEF);
        chk("t2_if_rvalid_not_yet", {31'd0, if_rvalid}, 32'd0);
        chk("t2_mem_addr_if", mem_addr, 32'h44);
        tick();
        chk("t2_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("t2_if_rdata", if_rdata, 32'h11112222);
        chk("t2_ls_rvalid_pulse", {31'd0, ls_rvalid}, 32'd0);
        tick();

        // 3: starvation, four LS grants then one forced fetch
        if_req = 1'b1; if_addr = 32'h80;
        ls_req = 1'b1; ls_addr = 32'h300; mem_rdata = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
                chk("t3_mem_addr_forced", mem_addr, 32'h80);
                if_addr = 32'h84;
            end
            #1;
            chk($sformatf("t3_if_gnt_%0d", i), {31'd0, if_gnt}, (i == 4) ? 32'd1 : 32'd0);
            chk($sformatf("t3_ls_gnt_%0d", i), {31'd0, ls_gnt}, (i == 4) ? 32'd0 : 32'd1);
            tick();
        end
        if_req = 1'b0; ls_req = 1'b0;
        tick(); tick(); tick();

        // 4: flush during a stalled fetch
        if_req = 1'b1; if_addr = 32'h180; mem_ready = 1'b0;
        #1 chk("t4_if_gnt", {31'd0, if_gnt}, 32'd1);
        tick();
        if_req = 1'b0;
        chk("t4_mem_valid", {31'd0, mem_valid}, 32'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_mem_valid_held", {31'd0, mem_valid}, 32'd1);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h55; if_req = 1'b1; if_addr = 32'h200;
        #1 chk("t4_if_gnt_next", {31'd0, if_gnt}, 32'd1);
        tick();
        if_req = 1'b0; mem_rdata = 32'h66;
        chk("t4_if_rvalid_dropped", {31'd0, if_rvalid}, 32'd0);
        chk("t4_mem_addr_next", mem_addr, 32'h200);
        tick();
        chk("t4_if_rvalid_next", {31'd0, if_rvalid}, 32'd1);
        chk("t4_if_rdata_next", if_rdata, 32'h66);
        tick();

        // 4b: flush with a fetch request and no LS request -> no grant, IDLE
        if_req = 1'b1; if_addr = 32'h240; flush = 1'b1;
        #1 chk("t4b_if_gnt_flush", {31'd0, if_gnt}, 32'd0);
        tick();
        chk("t4b_mem_valid", {31'd0, mem_valid}, 32'd0);
        flush = 1'b0;
        #1 chk("t4b_if_gnt_after", {31'd0, if_gnt}, 32'd1);
        tick();
        if_req = 1'b0;
        tick(); tick();

        // 5: byte store
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h7; ls_wdata = 32'hAB;
        mem_rdata = 32'hFFFFFFFF;
        #1 chk("t5_ls_gnt", {31'd0, ls_gnt}, 32'd1);
        tick();
        ls_req = 1'b0;
        chk("t5_mem_we", {31'd0, mem_we}, 32'd1);
        chk("t5_mem_size", {30'd0, mem_size}, 32'd0);
        chk("t5_mem_addr", mem_addr, 32'h7);
        chk("t5_mem_wdata", mem_wdata, 32'hAB);
        tick();
        chk("t5_ls_rvalid", {31'd0, ls_rvalid}, 32'd1);
        chk("t5_ls_rdata", ls_rdata, 32'd0);
        tick();

        // 6: reset while busy
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h20; mem_ready = 1'b0;
        #1 chk("t6_ls_gnt", {31'd0, ls_gnt}, 32'd1);
        tick();
        ls_req = 1'b0;
        chk("t6_mem_valid", {31'd0, mem_valid}, 32'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("t6_rst");
        ls_req = 1'b1;
        #1 chk("t6_ls_gnt_in_rst", {31'd0, ls_gnt}, 32'd0);
        ls_req = 1'b0;
        tick(); tick();
        rst = 1'b0; mem_ready = 1'b1;
        tick();
        chk("t6_ls_rvalid_after", {31'd0, ls_rvalid}, 32'd0);
        chk("t6_if_rvalid_after", {31'd0, if_rvalid}, 32'd0);
        chk("t6_mem_valid_after", {31'd0, mem_valid}, 32'd0);
        tick();
        chk("t6_ls_rvalid_after2", {31'd0, ls_rvalid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
